// File: rtl/ula_pkg.sv
// Shared key codes and controller states for the keypad calculator.
package ula_pkg;

  localparam logic [7:0] K_ON_OFF    = 8'd18;
  localparam logic [7:0] K_DEF_A     = 8'd15;
  localparam logic [7:0] K_DEF_B     = 8'd19;
  localparam logic [7:0] K_CLEAR_ALL = 8'd16;
  localparam logic [7:0] K_CHG_SIGN  = 8'd12;
  localparam logic [7:0] K_SUM       = 8'd26;
  localparam logic [7:0] K_MINUS     = 8'd30;
  localparam logic [7:0] K_DIGIT_MAX = 8'd9;

  typedef enum logic [1:0] {OFF, EDIT_A, EDIT_B} state_t;

endpackage

// File: rtl/ula_keypad_calc_key_strobe_sync.sv
// Synchronises the active-low keypad strobe and emits a one-cycle pulse per press.
module key_strobe_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic async_n,
  output logic key_stb
);

  // [0],[1] form the synchroniser, [2] holds the previous synchronised level.
  logic [2:0] sync_pipe;

  always_ff @(posedge clk) begin
    if (!rst_n) sync_pipe <= 3'b111;
    else        sync_pipe <= {sync_pipe[1:0], async_n};
  end

  assign key_stb = sync_pipe[2] & ~sync_pipe[1];

endmodule

// File: rtl/ula_keypad_calc.sv
// Keypad-driven signed two-operand calculator with decimal entry and sign-magnitude result.
module ula_keypad_calc
  import ula_pkg::*;
#(
  parameter  int DIGITS = 2,
  localparam int OW     = $clog2(10**DIGITS),
  localparam int RW     = $clog2(2*(10**DIGITS - 1) + 1)
) (
  input  logic          CLOCK_50,
  input  logic          rst_n,
  input  logic          validate,
  input  logic [7:0]    data,
  output logic          isOn,
  output logic          editB,
  output logic [OW-1:0] out_A,
  output logic          signA,
  output logic [OW-1:0] out_B,
  output logic          signB,
  output logic          opMinus,
  output logic [RW-1:0] value,
  output logic          signalR,
  output logic          key_err
);

  localparam int CW = 3;

  logic          key_stb;
  state_t        state, state_n;
  logic [OW-1:0] a_n, b_n;
  logic          sa_n, sb_n, op_n, err_n;
  logic [CW-1:0] cnt_a, cnt_b, cnt_a_n, cnt_b_n;

  key_strobe_sync u_sync (
    .clk     (CLOCK_50),
    .rst_n   (rst_n),
    .async_n (validate),
    .key_stb (key_stb)
  );

  always_ff @(posedge CLOCK_50) begin
    if (!rst_n) begin
      state   <= OFF;
      out_A   <= '0;
      out_B   <= '0;
      signA   <= 1'b0;
      signB   <= 1'b0;
      opMinus <= 1'b0;
      cnt_a   <= '0;
      cnt_b   <= '0;
      key_err <= 1'b0;
    end else begin
      state   <= state_n;
      out_A   <= a_n;
      out_B   <= b_n;
      signA   <= sa_n;
      signB   <= sb_n;
      opMinus <= op_n;
      cnt_a   <= cnt_a_n;
      cnt_b   <= cnt_b_n;
      key_err <= err_n;
    end
  end

  always_comb begin
    state_n = state;
    a_n     = out_A;
    b_n     = out_B;
    sa_n    = signA;
    sb_n    = signB;
    op_n    = opMinus;
    cnt_a_n = cnt_a;
    cnt_b_n = cnt_b;
    err_n   = 1'b0;
    if (key_stb) begin
      if (state == OFF) begin
        if (data == K_ON_OFF) begin
          state_n = EDIT_A;
          a_n = '0; b_n = '0; sa_n = 1'b0; sb_n = 1'b0;
          op_n = 1'b0; cnt_a_n = '0; cnt_b_n = '0;
        end else begin
          err_n = 1'b1;
        end
      end else begin
        case (data)
          K_ON_OFF: state_n = OFF;
          K_DEF_A: begin
            state_n = EDIT_A; a_n = '0; sa_n = 1'b0; cnt_a_n = '0;
          end
          K_DEF_B: begin
            state_n = EDIT_B; b_n = '0; sb_n = 1'b0; cnt_b_n = '0;
          end
          K_CLEAR_ALL: begin
            state_n = EDIT_A;
            a_n = '0; b_n = '0; sa_n = 1'b0; sb_n = 1'b0;
            op_n = 1'b0; cnt_a_n = '0; cnt_b_n = '0;
          end
          K_CHG_SIGN: begin
            if (state == EDIT_B) sb_n = ~signB;
            else                 sa_n = ~signA;
          end
          K_SUM:   op_n = 1'b0;
          K_MINUS: op_n = 1'b1;
          default: begin
            // Shift-in saturates at DIGITS; the magnitude always fits OW.
            if (data > K_DIGIT_MAX) begin
              err_n = 1'b1;
            end else if (state == EDIT_B) begin
              if (cnt_b < CW'(DIGITS)) begin
                b_n     = out_B * OW'(10) + OW'(data[3:0]);
                cnt_b_n = cnt_b + 1'b1;
              end else begin
                err_n = 1'b1;
              end
            end else begin
              if (cnt_a < CW'(DIGITS)) begin
                a_n     = out_A * OW'(10) + OW'(data[3:0]);
                cnt_a_n = cnt_a + 1'b1;
              end else begin
                err_n = 1'b1;
              end
            end
          end
        endcase
      end
    end
  end

  assign isOn  = (state != OFF);
  assign editB = (state == EDIT_B);

  logic [RW-1:0] mag_a, mag_b, res;
  logic          eff_sb, res_s;

  always_comb begin
    mag_a  = RW'(out_A);
    mag_b  = RW'(out_B);
    eff_sb = signB ^ opMinus;
    if (signA == eff_sb) begin
      res   = mag_a + mag_b;
      res_s = signA;
    end else if (mag_a >= mag_b) begin
      res   = mag_a - mag_b;
      res_s = signA;
    end else begin
      res   = mag_b - mag_a;
      res_s = eff_sb;
    end
    // Negative-zero operands must never surface as a -0 result.
    if (res == '0) res_s = 1'b0;
  end

  always_ff @(posedge CLOCK_50) begin
    if (!rst_n || state == OFF) begin
      value   <= '0;
      signalR <= 1'b0;
    end else begin
      value   <= res;
      signalR <= res_s;
    end
  end

endmodule

// File: tb/tb_ula_keypad_calc.sv
// Directed plus random keypad sequences checked against an integer reference model.
module tb_ula_keypad_calc;

  localparam int DIGITS = 2;
  localparam int OW = $clog2(10**DIGITS);
  localparam int RW = $clog2(2*(10**DIGITS - 1) + 1);

  logic          CLOCK_50 = 1'b0;
  logic          rst_n = 1'b0;
  logic          validate = 1'b1;
  logic [7:0]    data = 8'd0;
  logic          isOn, editB, signA, signB, opMinus, signalR, key_err;
  logic [OW-1:0] out_A, out_B;
  logic [RW-1:0] value;

  ula_keypad_calc #(.DIGITS(DIGITS)) dut (
    .CLOCK_50 (CLOCK_50),
    .rst_n    (rst_n),
    .validate (validate),
    .data     (data),
    .isOn     (isOn),
    .editB    (editB),
    .out_A    (out_A),
    .signA    (signA),
    .out_B    (out_B),
    .signB    (signB),
    .opMinus  (opMinus),
    .value    (value),
    .signalR  (signalR),
    .key_err  (key_err)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  int n_total = 0;
  int n_pass  = 0;
  int err_seen = 0;

  always @(negedge CLOCK_50) if (key_err === 1'b1) err_seen++;

  // Reference model: plain integers following the key rules.
  int m_on, m_eb, m_a, m_b, m_sa, m_sb, m_op, m_ca, m_cb, m_err;

  task automatic model_reset();
    m_on = 0; m_eb = 0; m_a = 0; m_b = 0; m_sa = 0; m_sb = 0;
    m_op = 0; m_ca = 0; m_cb = 0;
  endtask

  task automatic model_key(input int k);
    if (m_on == 0) begin
      if (k == 18) begin
        model_reset();
        m_on = 1;
      end else m_err++;
    end else begin
      case (k)
        18: m_on = 0;
        15: begin m_eb = 0; m_a = 0; m_sa = 0; m_ca = 0; end
        19: begin m_eb = 1; m_b = 0; m_sb = 0; m_cb = 0; end
        16: begin model_reset(); m_on = 1; end
        12: if (m_eb != 0) m_sb = 1 - m_sb; else m_sa = 1 - m_sa;
        26: m_op = 0;
        30: m_op = 1;
        default:
          if (k > 9) m_err++;
          else if (m_eb != 0) begin
            if (m_cb < DIGITS) begin m_b = m_b * 10 + k; m_cb++; end
            else m_err++;
          end else begin
            if (m_ca < DIGITS) begin m_a = m_a * 10 + k; m_ca++; end
            else m_err++;
          end
      endcase
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic check_all();
    int r, ev, es;
    r  = (m_sa != 0 ? -m_a : m_a) + (((m_sb ^ m_op) != 0) ? -m_b : m_b);
    ev = (m_on == 0) ? 0 : (r < 0 ? -r : r);
    es = (m_on != 0 && r < 0) ? 1 : 0;
    chk("isOn",    32'(isOn),    32'(m_on));
    chk("editB",   32'(editB),   32'(m_on != 0 ? m_eb : 0));
    chk("out_A",   32'(out_A),   32'(m_a));
    chk("signA",   32'(signA),   32'(m_sa));
    chk("out_B",   32'(out_B),   32'(m_b));
    chk("signB",   32'(signB),   32'(m_sb));
    chk("opMinus", 32'(opMinus), 32'(m_op));
    chk("value",   32'(value),   32'(ev));
    chk("signalR", 32'(signalR), 32'(es));
    chk("key_err_count", 32'(err_seen), 32'(m_err));
  endtask

  // Falling edge on validate, hold until the result register has updated, then release.
  task automatic press(input int k);
    @(posedge CLOCK_50); #1;
    data = 8'(k); validate = 1'b0;
    model_key(k);
    repeat (4) @(posedge CLOCK_50);
    #1;
    check_all();
    validate = 1'b1;
    repeat (3) @(posedge CLOCK_50);
  endtask

  task automatic press_seq(input int keys[$]);
    foreach (keys[i]) press(keys[i]);
  endtask

  initial begin
    int pick, k;
    int cmds[7] = '{18, 15, 19, 16, 12, 26, 30};
    m_err = 0;
    model_reset();
    repeat (3) @(posedge CLOCK_50);
    #1;
    check_all();
    rst_n = 1'b1;
    repeat (2) @(posedge CLOCK_50);
    #1;
    check_all();

    press(18);
    press_seq('{4, 7, 19, 1, 2});
    chk("tp_value_59", 32'(value), 32'd59);
    press(5);
    chk("tp_sat_B", 32'(out_B), 32'd12);
    chk("tp_sat_err", 32'(err_seen), 32'd1);

    press_seq('{16, 1, 2, 12, 19, 4, 7});
    chk("tp_value_35", 32'(value), 32'd35);
    press(30);
    chk("tp_value_m59", 32'(value), 32'd59);
    chk("tp_sign_m59", 32'(signalR), 32'd1);

    press_seq('{16, 2, 0, 19, 2, 0, 30});
    chk("tp_eq_zero", 32'(value), 32'd0);
    press_seq('{15, 2, 0, 12});
    chk("tp_value_40", 32'(value), 32'd40);
    chk("tp_sign_40", 32'(signalR), 32'd1);

    press_seq('{16, 12, 19, 12});
    chk("tp_neg_zero_sign", 32'(signalR), 32'd0);

    press_seq('{16, 9, 9, 19, 9, 9});
    chk("tp_value_198", 32'(value), 32'd198);
    press(16);

    press_seq('{3, 18, 5});
    chk("tp_off_A", 32'(out_A), 32'd3);
    press_seq('{200, 18, 255});

    // Reset lands between the validate edge and the register update.
    @(posedge CLOCK_50); #1;
    data = 8'd7; validate = 1'b0;
    @(posedge CLOCK_50); #1;
    rst_n = 1'b0;
    @(posedge CLOCK_50); #1;
    model_reset();
    check_all();
    validate = 1'b1;
    @(posedge CLOCK_50); #1;
    rst_n = 1'b1;
    repeat (4) @(posedge CLOCK_50);
    #1;
    check_all();

    for (int i = 0; i < 200; i++) begin
      pick = $urandom_range(0, 19);
      if (pick < 10)      k = pick;
      else if (pick < 17) k = cmds[pick - 10];
      else                k = $urandom_range(0, 255);
      press(k);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
